// File: rtl/mem19_pkg.sv
// Shared definitions for the 19-bit core's data-memory path: op encodings,
// responder FSM states and default geometry. The core imports the op codes.
package mem19_pkg;

    localparam int DATA_W_DEF      = 19;
    localparam int ADDR_W_DEF      = 10;
    localparam int DEPTH_DEF       = 1024;
    localparam int WAIT_STATES_DEF = 1;

    // 16'hA5A5 zero-extended to the full word width
    localparam logic [DATA_W_DEF-1:0] XOR_KEY_DEF = 19'h0A5A5;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_XFORM = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MODIFY,
        RESP
    } state_e;

    // The reserved encoding is reported as an error rather than executed
    function automatic logic op_is_reserved(input logic [1:0] op);
        return op == OP_RSVD;
    endfunction

endpackage

// File: rtl/mem19_if.sv
// Request/response channel between the core's MEM stage (master) and the
// data-memory responder (slave). Both channels are valid/ready.
interface mem19_if #(
    parameter int DATA_W = mem19_pkg::DATA_W_DEF,
    parameter int ADDR_W = mem19_pkg::ADDR_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/mem19_ram.sv
// Single-port synchronous word array with registered read. Read returns the
// pre-write contents when reading and writing the same word on one edge.
module mem19_ram #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              in_range;

    // Addresses past the implemented depth must never touch the array
    assign in_range = {1'b0, addr_i} < DEPTH_L;

    // Array write and registered read
    // NOTE: the array has no reset so it maps onto block RAM; contents survive a core reset.
    always_ff @(posedge clk_i) begin
        if (we_i && in_range) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (in_range) begin
            rdata_q <= mem_q[addr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem19_responder.sv
// Data-memory responder: accepts one request at a time, waits a fixed number
// of cycles, performs READ/WRITE or an atomic XOR read-modify-write, then
// holds the response until the initiator takes it.
module mem19_responder
    import mem19_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                DEPTH       = DEPTH_DEF,
    parameter int                WAIT_STATES = WAIT_STATES_DEF,
    parameter logic [DATA_W-1:0] XOR_KEY     = DATA_W'(XOR_KEY_DEF)
) (
    input  logic   clk1,
    input  logic   reset,
    mem19_if.slave bus
);
    // The wait counter is 4 bits wide and must not wrap
    if (WAIT_STATES > 15 || WAIT_STATES < 0) begin : g_bad_wait_states
        $error("mem19_responder: WAIT_STATES must be in 0..15");
    end

    localparam logic [3:0]      WS_L    = WAIT_STATES[3:0];
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_err;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign req_err = op_is_reserved(bus.req_op) || ({1'b0, bus.req_addr} >= DEPTH_L);

    mem19_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clk1),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // State and transaction registers
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state, datapath updates and array control
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;

        unique case (state_q)
            IDLE: begin
                // Present the incoming address so the registered read is
                // already valid during the first ACCESS cycle.
                ram_addr = bus.req_addr;
                if (bus.req_valid) begin
                    op_d    = op_e'(bus.req_op);
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = WS_L;
                    rdata_d = '0;
                    err_d   = req_err;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (err_q) begin
                    state_d = RESP;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    unique case (op_q)
                        OP_READ:  rdata_d = ram_rdata;
                        OP_WRITE: ram_we  = 1'b1;
                        OP_XFORM: rdata_d = ram_rdata;
                        default:  rdata_d = '0;
                    endcase
                    state_d = (op_q == OP_XFORM) ? MODIFY : RESP;
                end
            end
            MODIFY: begin
                // Old value already captured; no request can interleave here
                ram_we    = 1'b1;
                ram_wdata = rdata_q ^ XOR_KEY;
                state_d   = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule
